// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch, decode and execute over 3-5 cycles.
// Optional MCCTRL_ILLEGAL_TRAP_EN routes unknown opcodes to a TRAP state and adds o_illegal.
module multicycle_controller (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_zero,
    input  logic       i_memready,
    output logic       o_pcwrite,
    output logic       o_adrsrc,
    output logic       o_memwrite,
    output logic       o_irwrite,
    output logic [1:0] o_resultsrc,
    output logic [1:0] o_alusrca,
    output logic [1:0] o_alusrcb,
    output logic [1:0] o_immsrc,
    output logic       o_regwrite,
    output logic [2:0] o_alucrtl,
    output logic [3:0] o_state
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    ,
    output logic       o_illegal
`endif
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    // Moore part of the control word; fetch/beq mark the states whose PC/IR
    // enables are qualified by i_memready / i_zero in the same cycle.
    typedef struct packed {
        logic       adrsrc;
        logic       memwrite;
        logic       regwrite;
        logic       pc_always;
        logic       fetch;
        logic       beq;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
        logic       illegal;
`endif
    } ctrl_t;

    function automatic state_t next_state(input state_t s, input logic [6:0] op,
                                          input logic memready);
        state_t n;
        n = s;
        case (s)
            S_FETCH:    n = memready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: n = S_MEMADR;
                    OP_RTYPE:          n = S_EXECR;
                    OP_ITYPE:          n = S_EXECI;
                    OP_BEQ:            n = S_BEQ;
                    OP_JAL:            n = S_JAL;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
                    default:           n = S_TRAP;
`else
                    default:           n = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   n = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  n = memready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    n = S_FETCH;
            S_MEMWRITE: n = memready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    n = S_ALUWB;
            S_EXECI:    n = S_ALUWB;
            S_ALUWB:    n = S_FETCH;
            S_BEQ:      n = S_FETCH;
            S_JAL:      n = S_ALUWB;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
            S_TRAP:     n = S_TRAP;
`endif
            default:    n = S_FETCH;
        endcase
        return n;
    endfunction

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch     = 1'b1;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
            end
            S_DECODE: begin
                c.alusrca = 2'b01;
                c.alusrcb = 2'b01;
            end
            S_MEMADR: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
            end
            S_MEMREAD:  c.adrsrc = 1'b1;
            S_MEMWB: begin
                c.resultsrc = 2'b01;
                c.regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adrsrc   = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXECR: begin
                c.alusrca = 2'b10;
                c.aluop   = 2'b10;
            end
            S_EXECI: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
                c.aluop   = 2'b10;
            end
            S_ALUWB:    c.regwrite = 1'b1;
            S_BEQ: begin
                c.beq     = 1'b1;
                c.alusrca = 2'b10;
                c.aluop   = 2'b01;
            end
            S_JAL: begin
                c.pc_always = 1'b1;
                c.alusrca   = 2'b01;
                c.alusrcb   = 2'b10;
            end
`ifdef MCCTRL_ILLEGAL_TRAP_EN
            S_TRAP:     c.illegal = 1'b1;
`endif
            default:    c = '0;
        endcase
        return c;
    endfunction

    state_t state;
    ctrl_t  ctrl;

    // The control word is registered from the same next-state value as the
    // state itself, so both always describe the current state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_FETCH;
            ctrl  <= decode_ctrl(S_FETCH);
        end else begin
            state <= next_state(state, i_op, i_memready);
            ctrl  <= decode_ctrl(next_state(state, i_op, i_memready));
        end
    end

    assign o_state     = state;
    assign o_adrsrc    = ctrl.adrsrc;
    assign o_resultsrc = ctrl.resultsrc;
    assign o_alusrca   = ctrl.alusrca;
    assign o_alusrcb   = ctrl.alusrcb;

    // Write enables are held low for the whole reset cycle so an abandoned
    // instruction cannot commit anything.
    assign o_pcwrite  = ~i_rst & (ctrl.pc_always | (ctrl.fetch & i_memready) | (ctrl.beq & i_zero));
    assign o_irwrite  = ~i_rst & ctrl.fetch & i_memready;
    assign o_memwrite = ~i_rst & ctrl.memwrite;
    assign o_regwrite = ~i_rst & ctrl.regwrite;

`ifdef MCCTRL_ILLEGAL_TRAP_EN
    assign o_illegal = ctrl.illegal;
`endif

    always_comb begin
        o_alucrtl = ALU_ADD;
        case (ctrl.aluop)
            2'b00: o_alucrtl = ALU_ADD;
            2'b01: o_alucrtl = ALU_SUB;
            2'b10: begin
                case (i_funct3)
                    3'b000:  o_alucrtl = (i_op[5] & i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alucrtl = ALU_SLT;
                    3'b110:  o_alucrtl = ALU_OR;
                    3'b111:  o_alucrtl = ALU_AND;
                    default: o_alucrtl = ALU_ADD;
                endcase
            end
            default: o_alucrtl = ALU_ADD;
        endcase
    end

    always_comb begin
        o_immsrc = 2'b00;
        case (i_op)
            OP_STORE: o_immsrc = 2'b01;
            OP_BEQ:   o_immsrc = 2'b10;
            OP_JAL:   o_immsrc = 2'b11;
            default:  o_immsrc = 2'b00;
        endcase
    end

endmodule
